data_sram_responder: RTL

Memory-side responder for the CPU's data SRAM interface: it accepts `data_sram_en/we/addr/wdata` exactly as the core drives them and returns `data_sram_rdata` one cycle later. It decodes each access to either a local word-addressed RAM or a small confreg register window (LEDs, number display, switches, free-running timer, scratch registers). It sits outside `mycpu_top` in the SoC shell and is the block the core's EX-stage store/load traffic lands on in simulation and on the board.

---
 rtl/data_sram_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: memory-side responder for the core's data SRAM port.
// Decodes each access to a local word-addressed RAM or to the confreg window
// (scratch, timer, LED, number display, switches). Read data is returned one
// cycle after the access edge, read-first with respect to a same-edge write.
module data_sram_responder #(
  parameter int          RAM_AW     = 12,
  parameter int unsigned TIMER_STEP = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  input  logic [7:0]  switch
);

  localparam int          DATA_W   = 32;
  localparam int          RAM_DEPTH = 2 ** RAM_AW;
  localparam logic [15:0] CFG_BASE = 16'hBFAF;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(TIMER_STEP);

  localparam logic [15:0] OFF_SCR0   = 16'h8000;
  localparam logic [15:0] OFF_SCR1   = 16'h8004;
  localparam logic [15:0] OFF_SCR2   = 16'h8008;
  localparam logic [15:0] OFF_SCR3   = 16'h800C;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LED    = 16'hF020;
  localparam logic [15:0] OFF_NUM    = 16'hF050;
  localparam logic [15:0] OFF_SWITCH = 16'hF060;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [3:0]        lane_en
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Access decode (stage 0: inputs as sampled at the edge)
  logic                  is_cfg_p0;
  logic                  wr_p0;
  logic [RAM_AW-1:0]     ram_idx_p0;
  logic [15:0]           cfg_off_p0;
  logic [DATA_W-1:0]     cfg_rd_p0;

  // Architectural state
  logic [DATA_W-1:0]     scratch [4];
  logic [DATA_W-1:0]     timer;
  logic [DATA_W-1:0]     led_q;
  logic [DATA_W-1:0]     num_q;
  logic [7:0]            sw_sync_p0;
  logic [7:0]            sw_sync_p1;
  logic [DATA_W-1:0]     ram [RAM_DEPTH];

  // Read return (stage 1: one cycle after the access edge)
  logic [DATA_W-1:0]     ram_q_p1;
  logic [DATA_W-1:0]     cfg_q_p1;
  logic                  sel_ram_p1;
  logic                  rd_clr_p1;

  // Byte-offset bits carry no information for a word-wide port.
  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  assign is_cfg_p0  = (data_sram_addr[31:16] == CFG_BASE);
  assign wr_p0      = data_sram_en && (|data_sram_we);
  assign ram_idx_p0 = data_sram_addr[RAM_AW+1:2];
  assign cfg_off_p0 = data_sram_addr[15:0];

  // Confreg read mux over pre-edge register values.
  always_comb begin
    cfg_rd_p0 = '0;
    case (cfg_off_p0)
      OFF_SCR0, OFF_SCR1,
      OFF_SCR2, OFF_SCR3: cfg_rd_p0 = scratch[cfg_off_p0[3:2]];
      OFF_TIMER:          cfg_rd_p0 = timer;
      OFF_LED:            cfg_rd_p0 = led_q;
      OFF_NUM:            cfg_rd_p0 = num_q;
      OFF_SWITCH:         cfg_rd_p0 = {24'b0, sw_sync_p1};
      default:            cfg_rd_p0 = '0;
    endcase
  end

  // Confreg registers: timer free-runs, byte-masked stores override it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
      timer <= '0;
      led_q <= '0;
      num_q <= '0;
    end else begin
      timer <= timer + STEP;
      if (wr_p0 && is_cfg_p0) begin
        case (cfg_off_p0)
          OFF_SCR0, OFF_SCR1,
          OFF_SCR2, OFF_SCR3: scratch[cfg_off_p0[3:2]] <=
                                byte_merge(scratch[cfg_off_p0[3:2]], data_sram_wdata, data_sram_we);
          OFF_TIMER:          timer <= byte_merge(timer, data_sram_wdata, data_sram_we);
          OFF_LED:            led_q <= byte_merge(led_q, data_sram_wdata, data_sram_we);
          OFF_NUM:            num_q <= byte_merge(num_q, data_sram_wdata, data_sram_we);
          default: ;
        endcase
      end
    end
  end

  // Two-flop synchroniser for the asynchronous board switches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_sync_p0 <= '0;
      sw_sync_p1 <= '0;
    end else begin
      sw_sync_p0 <= switch;
      sw_sync_p1 <= sw_sync_p0;
    end
  end

  // Local RAM: read-first word fetch plus byte-lane store; contents are never reset.
  always_ff @(posedge clk) begin
    if (data_sram_en && !is_cfg_p0) begin
      ram_q_p1 <= ram[ram_idx_p0];
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) ram[ram_idx_p0][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read-return control: source select and the post-reset zero override.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q_p1   <= '0;
      sel_ram_p1 <= 1'b0;
      rd_clr_p1  <= 1'b1;
    end else if (data_sram_en) begin
      cfg_q_p1   <= cfg_rd_p0;
      sel_ram_p1 <= !is_cfg_p0;
      rd_clr_p1  <= 1'b0;
    end
  end

  // The RAM word flop has no reset, so rd_clr_p1 forces zero until the next access.
  assign data_sram_rdata = rd_clr_p1  ? '0       :
                           sel_ram_p1 ? ram_q_p1 : cfg_q_p1;
  assign led      = led_q[15:0];
  assign num_data = num_q;

endmodule
